// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter that shares one AXI-lite slave port between NUM_REQ masters.
// One transaction (read or write) is outstanding at a time, and the registered grant steers every channel.
module axi_lite_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // Master-side ports
    input  logic [NUM_REQ-1:0]            m_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0]     m_araddr,
    output logic [NUM_REQ-1:0]            m_arready,
    output logic [NUM_REQ-1:0]            m_rvalid,
    input  logic [NUM_REQ-1:0]            m_rready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [1:0]                    m_rresp,
    input  logic [NUM_REQ-1:0]            m_awvalid,
    output logic [NUM_REQ-1:0]            m_awready,
    input  logic [NUM_REQ*ADDR_W-1:0]     m_awaddr,
    input  logic [NUM_REQ-1:0]            m_wvalid,
    output logic [NUM_REQ-1:0]            m_wready,
    input  logic [NUM_REQ*DATA_W-1:0]     m_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   m_wstrb,
    output logic [NUM_REQ-1:0]            m_bvalid,
    input  logic [NUM_REQ-1:0]            m_bready,
    output logic [1:0]                    m_bresp,
    // Slave-side port
    output logic [ADDR_W-1:0]             s_araddr,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    input  logic [1:0]                    s_bresp,
    // Status
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW    = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] req;
    logic [IDW-1:0]   winner;
    logic             found;
    logic [IDW-1:0]   next_ptr;
    int               idx;

    // Search starts at rr_ptr so the previous owner has the lowest priority next round.
    always_comb begin
        req    = m_arvalid | m_awvalid;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        if (grant_id_q == IDW'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_id_q + IDW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    state_d    = m_arvalid[winner] ? RD : WR;
                end
            end
            RD: begin
                if (s_rvalid && s_rready) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            WR: begin
                if (s_bvalid && s_bready) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Handshakes are gated by the registered state so IDLE never lets a beat through.
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;

        s_araddr  = m_araddr[int'(grant_id_q)*ADDR_W +: ADDR_W];
        s_awaddr  = m_awaddr[int'(grant_id_q)*ADDR_W +: ADDR_W];
        s_wdata   = m_wdata[int'(grant_id_q)*DATA_W +: DATA_W];
        s_wstrb   = m_wstrb[int'(grant_id_q)*STRB_W +: STRB_W];

        s_arvalid = (state_q == RD) && m_arvalid[grant_id_q];
        s_rready  = (state_q == RD) && m_rready[grant_id_q];
        s_awvalid = (state_q == WR) && m_awvalid[grant_id_q];
        s_wvalid  = (state_q == WR) && m_wvalid[grant_id_q];
        s_bready  = (state_q == WR) && m_bready[grant_id_q];

        m_arready[grant_id_q] = (state_q == RD) && s_arready;
        m_rvalid[grant_id_q]  = (state_q == RD) && s_rvalid;
        m_awready[grant_id_q] = (state_q == WR) && s_awready;
        m_wready[grant_id_q]  = (state_q == WR) && s_wready;
        m_bvalid[grant_id_q]  = (state_q == WR) && s_bvalid;

        m_rdata = s_rdata;
        m_rresp = s_rresp;
        m_bresp = s_bresp;
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter: two masters driven by tasks, one behavioural AXI-lite slave.
// The slave returns rdata = araddr ^ 32'hDEAD_BFEF, rresp/bresp = addr[5:4].
module tb_axi_lite_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam logic [31:0] K = 32'hDEAD_BFEF;

    logic clk, rst_n;
    logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N*AW-1:0] m_araddr, m_awaddr;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp, m_bresp;
    logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [AW-1:0]   s_araddr, s_awaddr;
    logic            s_arvalid, s_arready, s_rvalid, s_rready;
    logic [DW-1:0]   s_rdata, s_wdata;
    logic [1:0]      s_rresp, s_bresp;
    logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [SW-1:0]   s_wstrb;
    logic [0:0]      grant_id;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    int b_delay = 0;
    logic [31:0] slv_araddr, slv_awaddr, slv_wdata;
    logic [3:0]  slv_wstrb;

    int log_kind[$];
    int log_gid[$];

    logic [31:0] rd_d[4];
    logic [1:0]  rd_r[4];
    int          rd_g[4];
    bit          rd_t[4];
    bit          wr_done;

    axi_lite_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Completion log: one entry per slave-side R or B handshake.
    always @(negedge clk) begin
        if (rst_n && s_rvalid && s_rready) begin
            log_kind.push_back(0);
            log_gid.push_back(int'(grant_id));
        end
        if (rst_n && s_bvalid && s_bready) begin
            log_kind.push_back(1);
            log_gid.push_back(int'(grant_id));
        end
    end

    // Behavioural slave: samples at negedge, updates just after posedge.
    initial begin : slave
        bit rst_s, ar_hs, r_hs, aw_hs, w_hs, b_hs, got_aw, got_w, b_pend;
        logic [31:0] araddr_s, awaddr_s, wdata_s;
        logic [3:0]  wstrb_s;
        int b_wait;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = '0;
        got_aw = 0; got_w = 0; b_pend = 0; b_wait = 0;
        forever begin
            @(negedge clk);
            rst_s = rst_n;
            ar_hs = s_arvalid && s_arready; araddr_s = s_araddr;
            r_hs  = s_rvalid && s_rready;
            aw_hs = s_awvalid && s_awready; awaddr_s = s_awaddr;
            w_hs  = s_wvalid && s_wready; wdata_s = s_wdata; wstrb_s = s_wstrb;
            b_hs  = s_bvalid && s_bready;
            @(posedge clk); #1;
            if (!rst_s) begin
                s_rvalid = 1'b0; s_bvalid = 1'b0;
                got_aw = 0; got_w = 0; b_pend = 0;
            end else begin
                if (r_hs) s_rvalid = 1'b0;
                if (ar_hs) begin
                    s_rvalid = 1'b1; s_rdata = araddr_s ^ K;
                    s_rresp = araddr_s[5:4]; slv_araddr = araddr_s;
                end
                if (b_hs) s_bvalid = 1'b0;
                if (aw_hs) begin got_aw = 1; slv_awaddr = awaddr_s; end
                if (w_hs) begin got_w = 1; slv_wdata = wdata_s; slv_wstrb = wstrb_s; end
                if (b_pend) begin
                    if (b_wait == 0) begin
                        s_bvalid = 1'b1; s_bresp = slv_awaddr[5:4]; b_pend = 0;
                    end else begin
                        b_wait--;
                    end
                end else if (got_aw && got_w) begin
                    got_aw = 0; got_w = 0; b_pend = 1; b_wait = b_delay;
                end
            end
        end
    end

    task automatic master_read(input int m, input logic [31:0] addr, output logic [31:0] data,
                               output logic [1:0] resp, output int gid, output bit tmo);
        bit got, ar_d;
        int n;
        got = 0; ar_d = 0; n = 0; data = '0; resp = '0; gid = -1;
        @(posedge clk); #1;
        m_arvalid[m] = 1'b1; m_araddr[m*AW +: AW] = addr; m_rready[m] = 1'b1;
        while (!got && n < 100) begin
            @(negedge clk); n++;
            if (m_arvalid[m] && m_arready[m]) ar_d = 1;
            if (m_rvalid[m]) begin data = m_rdata; resp = m_rresp; gid = int'(grant_id); got = 1; end
            @(posedge clk); #1;
            if (ar_d) m_arvalid[m] = 1'b0;
        end
        m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
        tmo = !got;
    endtask

    task automatic master_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, output logic [1:0] resp,
                                output int gid, output bit tmo);
        bit got, aw_d, w_d;
        int n;
        got = 0; n = 0; resp = '0; gid = -1;
        @(posedge clk); #1;
        m_awvalid[m] = 1'b1; m_awaddr[m*AW +: AW] = addr;
        m_wvalid[m] = 1'b1; m_wdata[m*DW +: DW] = data; m_wstrb[m*SW +: SW] = strb;
        m_bready[m] = 1'b1;
        while (!got && n < 100) begin
            @(negedge clk); n++;
            aw_d = m_awvalid[m] && m_awready[m];
            w_d  = m_wvalid[m] && m_wready[m];
            if (m_bvalid[m]) begin resp = m_bresp; gid = int'(grant_id); got = 1; end
            @(posedge clk); #1;
            if (aw_d) m_awvalid[m] = 1'b0;
            if (w_d) m_wvalid[m] = 1'b0;
        end
        m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0; m_bready[m] = 1'b0;
        tmo = !got;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_arvalid = '0; m_araddr = '0; m_rready = '0;
        m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_bready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || grant_id !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: busy=%b grant_id=%0d, required 0 and 0", busy, grant_id);
        end
        n_checks++;
        if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_s_valids: got %b required 00000",
                               {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready});
        end
        n_checks++;
        if ({m_arready, m_rvalid, m_awready, m_wready, m_bvalid} !== '0) begin
            n_fail++; $display("FAIL reset_m_outputs: got %b required all 0",
                               {m_arready, m_rvalid, m_awready, m_wready, m_bvalid});
        end
        n_checks++;
        if ($isunknown({s_araddr, s_awaddr, s_wdata, s_wstrb})) begin
            n_fail++; $display("FAIL reset_s_data_known: s_araddr=%h s_awaddr=%h required no X", s_araddr, s_awaddr);
        end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        master_read(0, 32'h100, rd_d[0], rd_r[0], rd_g[0], rd_t[0]);
        n_checks++;
        if (rd_t[0] !== 1'b0 || rd_d[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_read_data: got %h (timeout=%0d) required deadbeef", rd_d[0], rd_t[0]);
        end
        n_checks++;
        if (rd_g[0] !== 0 || rd_r[0] !== 2'b00) begin
            n_fail++; $display("FAIL single_read_grant: gid=%0d resp=%0d required 0 and 0", rd_g[0], rd_r[0]);
        end
        n_checks++;
        if (slv_araddr !== 32'h100) begin
            n_fail++; $display("FAIL single_read_addr: slave saw %h required 00000100", slv_araddr);
        end
        n_checks++;
        if (dut.rr_ptr_q !== 1'b1) begin
            n_fail++; $display("FAIL single_read_rr_ptr: got %0d required 1", dut.rr_ptr_q);
        end
    endtask

    task automatic test_simultaneous();
        bit sav[40], sbz[40];
        int first, last, rises, gap;
        pulse_reset();
        log_kind.delete(); log_gid.delete();
        fork
            master_read(0, 32'h104, rd_d[0], rd_r[0], rd_g[0], rd_t[0]);
            master_read(1, 32'h208, rd_d[1], rd_r[1], rd_g[1], rd_t[1]);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk); sav[i] = s_arvalid; sbz[i] = busy;
            end
        join
        n_checks++;
        if (log_gid.size() != 2 || log_gid[0] != 0 || log_gid[1] != 1) begin
            n_fail++; $display("FAIL simul_order: %0d completions, first gid %0d, required 2 completions order 0,1",
                               log_gid.size(), (log_gid.size() > 0) ? log_gid[0] : -1);
        end
        n_checks++;
        if (rd_t[0] || rd_t[1] || rd_d[0] !== (32'h104 ^ K) || rd_d[1] !== (32'h208 ^ K)) begin
            n_fail++; $display("FAIL simul_data: m0=%h m1=%h required %h %h",
                               rd_d[0], rd_d[1], 32'h104 ^ K, 32'h208 ^ K);
        end
        first = -1; last = -1; rises = 0; gap = 0;
        for (int i = 0; i < 40; i++) begin
            if (sav[i]) begin
                if (first < 0) first = i;
                last = i;
                if (i == 0 || !sav[i-1]) rises++;
            end
        end
        for (int i = 0; i < 40; i++) if (i > first && i < last && !sbz[i]) gap++;
        n_checks++;
        if (rises != 2 || gap != 1) begin
            n_fail++; $display("FAIL simul_gap: s_arvalid pulses=%0d idle cycles between=%0d required 2 and 1", rises, gap);
        end
        n_checks++;
        if (dut.rr_ptr_q !== 1'b0) begin
            n_fail++; $display("FAIL simul_rr_ptr: got %0d required 0", dut.rr_ptr_q);
        end
    endtask

    task automatic test_alternate();
        log_kind.delete(); log_gid.delete();
        fork
            begin
                master_read(0, 32'h300, rd_d[0], rd_r[0], rd_g[0], rd_t[0]);
                master_read(0, 32'h304, rd_d[2], rd_r[2], rd_g[2], rd_t[2]);
            end
            begin
                master_read(1, 32'h400, rd_d[1], rd_r[1], rd_g[1], rd_t[1]);
                master_read(1, 32'h404, rd_d[3], rd_r[3], rd_g[3], rd_t[3]);
            end
        join
        n_checks++;
        if (log_gid.size() != 4 || log_gid[0] != 0 || log_gid[1] != 1 || log_gid[2] != 0 || log_gid[3] != 1) begin
            n_fail++; $display("FAIL alternate_order: %0d completions (%0d,%0d,..) required 4 in order 0,1,0,1",
                               log_gid.size(), (log_gid.size() > 0) ? log_gid[0] : -1,
                               (log_gid.size() > 1) ? log_gid[1] : -1);
        end
        n_checks++;
        if (rd_d[2] !== (32'h304 ^ K) || rd_d[3] !== (32'h404 ^ K) || rd_t[2] || rd_t[3]) begin
            n_fail++; $display("FAIL alternate_data: m0=%h m1=%h required %h %h",
                               rd_d[2], rd_d[3], 32'h304 ^ K, 32'h404 ^ K);
        end
    endtask

    task automatic test_write_isolation();
        int bad_b0, bad_ar0, gaps, busy_cyc, n;
        bit seen, stop;
        logic [1:0] bresp;
        int bgid;
        bit btmo;
        bad_b0 = 0; bad_ar0 = 0; gaps = 0; busy_cyc = 0; n = 0; seen = 0; stop = 0;
        b_delay = 5; wr_done = 0;
        log_kind.delete(); log_gid.delete();
        fork
            begin
                master_write(1, 32'h20, 32'h55AA, 4'hF, bresp, bgid, btmo);
                wr_done = 1;
            end
            begin
                repeat (2) @(posedge clk);
                master_read(0, 32'h40, rd_d[0], rd_r[0], rd_g[0], rd_t[0]);
            end
            while (!stop && n < 200) begin
                @(negedge clk); n++;
                if (wr_done) stop = 1;
                else begin
                    if (m_bvalid[0]) bad_b0++;
                    if (busy && m_arready[0]) bad_ar0++;
                    if (seen && !busy) gaps++;
                    if (busy) begin seen = 1; busy_cyc++; end
                end
            end
        join
        b_delay = 0;
        n_checks++;
        if (btmo || bresp !== 2'b10 || bgid != 1) begin
            n_fail++; $display("FAIL write_bresp: resp=%0d gid=%0d timeout=%0d required 2, 1, 0", bresp, bgid, btmo);
        end
        n_checks++;
        if (slv_awaddr !== 32'h20 || slv_wdata !== 32'h55AA || slv_wstrb !== 4'hF) begin
            n_fail++; $display("FAIL write_fwd: addr=%h data=%h strb=%h required 20 55aa f",
                               slv_awaddr, slv_wdata, slv_wstrb);
        end
        n_checks++;
        if (gaps != 0 || busy_cyc < 7) begin
            n_fail++; $display("FAIL write_busy: busy drops=%0d busy cycles=%0d required 0 and >=7", gaps, busy_cyc);
        end
        n_checks++;
        if (bad_b0 != 0 || bad_ar0 != 0) begin
            n_fail++; $display("FAIL write_isolation: m0 bvalid cycles=%0d m0 arready cycles=%0d required 0 0",
                               bad_b0, bad_ar0);
        end
        n_checks++;
        if (rd_t[0] || rd_d[0] !== (32'h40 ^ K) || log_kind.size() != 2 || log_gid[1] != 0) begin
            n_fail++; $display("FAIL write_then_read: data=%h completions=%0d required %h and 2",
                               rd_d[0], log_kind.size(), 32'h40 ^ K);
        end
    endtask

    task automatic test_read_before_write();
        logic [1:0] bresp;
        int bgid;
        bit btmo;
        log_kind.delete(); log_gid.delete();
        fork
            master_read(0, 32'h80, rd_d[0], rd_r[0], rd_g[0], rd_t[0]);
            master_write(0, 32'h84, 32'h1234_5678, 4'h3, bresp, bgid, btmo);
        join
        n_checks++;
        if (log_kind.size() != 2 || log_kind[0] != 0 || log_kind[1] != 1) begin
            n_fail++; $display("FAIL rbw_order: %0d completions, first kind %0d, required 2 with read(0) then write(1)",
                               log_kind.size(), (log_kind.size() > 0) ? log_kind[0] : -1);
        end
        n_checks++;
        if (rd_t[0] || btmo || rd_d[0] !== (32'h80 ^ K) || slv_awaddr !== 32'h84 || slv_wstrb !== 4'h3) begin
            n_fail++; $display("FAIL rbw_data: rdata=%h awaddr=%h wstrb=%h required %h 84 3",
                               rd_d[0], slv_awaddr, slv_wstrb, 32'h80 ^ K);
        end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        m_arvalid[1] = 1'b1; m_araddr[AW +: AW] = 32'h500; m_rready[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_arvalid[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 1'b1 || m_rvalid[1] !== 1'b1) begin
            n_fail++; $display("FAIL midrd_before: busy=%b grant_id=%0d m_rvalid=%b required 1 1 1",
                               busy, grant_id, m_rvalid[1]);
        end
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || grant_id !== 1'b0 || dut.rr_ptr_q !== 1'b0) begin
            n_fail++; $display("FAIL midrd_state: busy=%b grant_id=%0d rr_ptr=%0d required 0 0 0",
                               busy, grant_id, dut.rr_ptr_q);
        end
        n_checks++;
        if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m_arready, m_rvalid, m_awready, m_wready, m_bvalid} !== '0) begin
            n_fail++; $display("FAIL midrd_valids: got %b required all 0",
                               {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
                                m_arready, m_rvalid, m_awready, m_wready, m_bvalid});
        end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_alternate();
        test_write_isolation();
        test_read_before_write();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
